deserial_correct: RTL

- Receive-side counterpart of the `buff` serializer: the reassembly and correction stage behind `xilinx_decoder`.
- Holds the raw (possibly errored) DATA_BITS word and consumes the decoder's BITS-wide error-pattern stream, which is marked by a first-chunk strobe.
- XORs each chunk into the matching slice of the word, then presents the corrected word with a one-cycle valid pulse and an error-weight report.

---
 rtl/deserial_correct_pkg.sv | 18 +
 rtl/deserial_correct_popcount.sv | 21 ++
 rtl/deserial_correct.sv | 124 ++++++++++++
 3 files changed

// File: rtl/deserial_correct_pkg.sv
// Shared constants and state encoding for the receive-side correction stage.
// Defaults match the serializer and the encoder/decoder pair.
// No logic lives here.
package deserial_correct_pkg;

    localparam int DATA_BITS_DEF = 64;
    localparam int BITS_DEF      = 8;
    localparam int T_DEF         = 4;
    localparam int CHUNKS_DEF    = DATA_BITS_DEF / BITS_DEF;
    localparam int CNT_W_DEF     = $clog2(DATA_BITS_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/deserial_correct_popcount.sv
// Purpose: population count of a BITS-wide vector.
// Latency: combinational.
// Backpressure: none.
module popcount_bits #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0]           bits_in,
    output logic [$clog2(BITS+1)-1:0] count_out
);

    localparam int OUT_W = $clog2(BITS + 1);

    // Sum of the individual bits; synthesis reshapes this into a balanced tree.
    always_comb begin
        count_out = '0;
        for (int i = 0; i < BITS; i++) begin
            count_out = count_out + OUT_W'(bits_in[i]);
        end
    end

endmodule

// File: rtl/deserial_correct.sv
// Purpose: apply a chunked MSB-first error pattern to a held raw word and report the error weight.
// Latency: start_in at cycle 0 gives valid_out at cycle CHUNKS.
// Backpressure: none; the chunk stream is contiguous, and a new start_in abandons any open frame.
module deserial_correct
    import deserial_correct_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int BITS      = BITS_DEF,
    parameter int T         = T_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_in,
    input  logic [DATA_BITS-1:0]           raw_in,
    input  logic                           start_in,
    input  logic [BITS-1:0]                err_in,
    output logic [DATA_BITS-1:0]           word_out,
    output logic                           valid_out,
    output logic                           busy,
    output logic [$clog2(DATA_BITS+1)-1:0] err_count,
    output logic                           fail_out
);

    localparam int CHUNKS = DATA_BITS / BITS;
    localparam int CNT_W  = $clog2(DATA_BITS + 1);
    localparam int IDX_W  = $clog2(CHUNKS + 1);
    localparam int POP_W  = $clog2(BITS + 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] work_q, work_d;
    logic [CNT_W-1:0]     weight_q, weight_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     errc_q, errc_d;
    logic                 fail_q, fail_d;

    logic [POP_W-1:0]     pop;
    logic                 consume;
    logic [IDX_W-1:0]     cur_idx;
    logic [DATA_BITS-1:0] base_work, placed, acc_work;
    logic [CNT_W-1:0]     base_weight, acc_weight;

    popcount_bits #(.BITS(BITS)) u_pop (
        .bits_in   (err_in),
        .count_out (pop)
    );

    // A chunk is consumed on every start_in cycle (chunk 0, fresh source) and on every
    // COLLECT cycle (next chunk); the last chunk publishes results instead of staying open.
    always_comb begin
        consume     = 1'b0;
        cur_idx     = '0;
        base_work   = work_q;
        base_weight = weight_q;
        state_d     = ST_IDLE;
        work_d      = work_q;
        weight_d    = weight_q;
        idx_d       = idx_q;
        word_d      = word_q;
        errc_d      = errc_q;
        fail_d      = fail_q;

        if (start_in) begin
            consume     = 1'b1;
            base_work   = load_in ? raw_in : hold_q;
            base_weight = '0;
        end else if (state_q == ST_COLLECT) begin
            consume = 1'b1;
            cur_idx = idx_q;
        end

        // Chunk k lands in bits [DATA_BITS-1-k*BITS -: BITS].
        placed     = DATA_BITS'(err_in) << (BITS * (CHUNKS - 1 - int'(cur_idx)));
        acc_work   = base_work ^ placed;
        acc_weight = base_weight + CNT_W'(pop);

        if (consume) begin
            if (int'(cur_idx) == CHUNKS - 1) begin
                state_d = ST_DONE;
                word_d  = acc_work;
                errc_d  = acc_weight;
                fail_d  = (acc_weight > CNT_W'(T));
            end else begin
                state_d  = ST_COLLECT;
                work_d   = acc_work;
                weight_d = acc_weight;
                idx_d    = cur_idx + IDX_W'(1);
            end
        end
    end

    // State, working registers and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            work_q   <= '0;
            weight_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            errc_q   <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            weight_q <= weight_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            errc_q   <= errc_d;
            fail_q   <= fail_d;
            if (load_in) begin
                hold_q <= raw_in;
            end
        end
    end

    assign valid_out = (state_q == ST_DONE);
    assign busy      = (state_q == ST_COLLECT);
    assign word_out  = word_q;
    assign err_count = errc_q;
    assign fail_out  = fail_q;

endmodule
